reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 70 +++++++
 tb/tb_reset_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronised RST_N release followed by a staggered, counted release of NUM_OUT reset channels.
// Define RESET_SEQ_COUNT_EN to add RST_COUNT, a saturating count of completed sequences.
module reset_sequencer #(
    parameter int NUM_OUT     = 4,
    parameter int RSTDELAY    = 1,
    parameter int STAGGER     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               SW_RST,
    output logic [NUM_OUT-1:0] OUT_RST_N,
`ifdef RESET_SEQ_COUNT_EN
    output logic [7:0]         RST_COUNT,
`endif
    output logic               DONE
);
    localparam int TOTAL = RSTDELAY + (NUM_OUT - 1) * STAGGER;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d, elapsed;
    logic [NUM_OUT-1:0]     out_d;
    logic                   in_assert, go;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q    <= '0;
            state_q   <= ASSERT;
            cnt_q     <= '0;
            OUT_RST_N <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            OUT_RST_N <= out_d;
        end
    end

    // The edge that leaves ASSERT (or first samples SW_RST low) already counts as one elapsed cycle.
    always_comb begin
        in_assert = state_q == ASSERT;
        go        = in_assert ? sync_q[SYNC_STAGES-1] : !SW_RST;
        cnt_d     = in_assert ? (go ? CW'(TOTAL - 1) : '0)
                  : SW_RST    ? CW'(TOTAL)
                  : (cnt_q == '0 ? '0 : cnt_q - CW'(1));
        elapsed   = CW'(TOTAL) - cnt_d;
        out_d     = '0;
        for (int i = 0; i < NUM_OUT; i++)
            out_d[i] = go && elapsed >= CW'(RSTDELAY + i * STAGGER);
        state_d   = (in_assert && !go) ? ASSERT
                  : out_d[NUM_OUT-1]   ? RUN
                  : out_d[0]           ? RELEASE
                  : HOLD;
    end

`ifdef RESET_SEQ_COUNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            RST_COUNT <= '0;
        else if (out_d[NUM_OUT-1] && !OUT_RST_N[NUM_OUT-1] && RST_COUNT != 8'hFF)
            RST_COUNT <= RST_COUNT + 8'd1;
    end
`endif

    assign DONE = OUT_RST_N[NUM_OUT-1];
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized check of reset_sequencer against an edge-numbering release model.
module tb_reset_sequencer;
    localparam int NO = 3, DL = 4, ST = 2, SS = 2;

    logic          CLK = 1'b0, RST_N = 1'b0, SW_RST = 1'b0;
    logic [NO-1:0] out_a;
    logic          done_a, done_b;
    logic [3:0]    out_b;
`ifdef RESET_SEQ_COUNT_EN
    logic [7:0]    cnt_a, cnt_b;
`endif

    int checks = 0, errors = 0;
    int m_n = 0, m_cnt = 0;
    bit m_sw = 0, m_done = 0;

    always #5 CLK = ~CLK;

    reset_sequencer #(.NUM_OUT(NO), .RSTDELAY(DL), .STAGGER(ST), .SYNC_STAGES(SS)) u_a (
        .CLK(CLK), .RST_N(RST_N), .SW_RST(SW_RST), .OUT_RST_N(out_a),
`ifdef RESET_SEQ_COUNT_EN
        .RST_COUNT(cnt_a),
`endif
        .DONE(done_a)
    );

    reset_sequencer #(.NUM_OUT(4), .RSTDELAY(1), .STAGGER(0), .SYNC_STAGES(3)) u_b (
        .CLK(CLK), .RST_N(RST_N), .SW_RST(SW_RST), .OUT_RST_N(out_b),
`ifdef RESET_SEQ_COUNT_EN
        .RST_COUNT(cnt_b),
`endif
        .DONE(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel i is released once the edge count since the sequence start reaches its offset.
    function automatic logic [NO-1:0] exp_out();
        logic [NO-1:0] e;
        for (int i = 0; i < NO; i++)
            e[i] = m_n >= (m_sw ? 0 : SS) + DL + i * ST;
        return e;
    endfunction

    task automatic model_edge();
        logic [NO-1:0] e;
        if (RST_N) begin
            m_n++;
            if (SW_RST && (m_sw || m_n > SS + 1)) begin
                m_sw = 1;
                m_n  = 0;
            end
        end
        e = exp_out();
        if (e[NO-1] && !m_done && m_cnt < 255) m_cnt++;
        m_done = e[NO-1];
    endtask

    task automatic check_all();
        check("out", out_a, exp_out());
        check("done", done_a, m_done);
`ifdef RESET_SEQ_COUNT_EN
        check("count", cnt_a, m_cnt);
`endif
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            model_edge();
            #2;
            check_all();
        end
    endtask

    task automatic async_drop();
        RST_N = 1'b0;
        #1;
        m_n = 0; m_sw = 0; m_done = 0; m_cnt = 0;
        check_all();
    endtask

    initial begin
        step(3);
        check("rst_b", out_b, 4'h0);
        RST_N = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t025", out_a, k >= 10 ? 7 : k >= 8 ? 3 : k >= 6 ? 1 : 0);
            check("t028", out_b, k >= 4 ? 4'hF : 4'h0);
            check("t028_done", done_b, k >= 4);
        end
        SW_RST = 1'b1;
        step();
        SW_RST = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t026", out_a, k >= 8 ? 7 : k >= 6 ? 3 : k >= 4 ? 1 : 0);
        end
        step(7);
        async_drop();
        step(2);
        RST_N = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t027", out_a, k >= 10 ? 7 : k >= 8 ? 3 : k >= 6 ? 1 : 0);
        end
        SW_RST = 1'b1;
        step();
        SW_RST = 1'b0;
        step(5);
        SW_RST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t029_hold", out_a, 0);
        end
        SW_RST = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t029", out_a, k >= 8 ? 7 : k >= 6 ? 3 : k >= 4 ? 1 : 0);
        end
        repeat (150) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) step($urandom_range(1, 6));
            else if (r < 8) begin
                SW_RST = 1'b1;
                step($urandom_range(1, 12));
                SW_RST = 1'b0;
            end else begin
                async_drop();
                step($urandom_range(0, 2));
                RST_N = 1'b1;
            end
        end
        step(12);
        repeat (300) begin
            SW_RST = 1'b1;
            step();
            SW_RST = 1'b0;
            step(9);
        end
`ifdef RESET_SEQ_COUNT_EN
        check("t030_sat", cnt_a, 255);
`endif
        async_drop();
`ifdef RESET_SEQ_COUNT_EN
        check("t030_clr", cnt_a, 0);
`endif
        step();
        RST_N = 1'b1;
        step(12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
